// File: rtl/flag_unit.sv
// flag_unit: producer of the {carry,zero,sign} branch-flag vector.
// Captures flags from flag-setting ALU ops, tracks one outstanding op and
// stalls conditional branches in decode while flags are stale.
// Optional feature macro: FLAG_FORWARD_EN (forward fresh flags in the done cycle).
module flag_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alu_start,
  input  logic              i_alu_done,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_carry,
  input  logic [2:0]        i_condition,
  output logic [2:0]        o_flags,
  output logic              o_flags_valid,
  output logic              o_branch_stall,
  output logic              o_proto_err,
  output logic [CNT_W-1:0]  o_upd_count
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_flags;
  logic             r_proto_err;
  logic [CNT_W-1:0] r_upd_count;

  logic [2:0]       w_new_flags;
  logic             w_accept;
  logic             w_perr_set;
  logic             w_is_branch;

  // A done only counts when an op is actually outstanding.
  assign w_accept    = (r_state == PENDING) && i_alu_done;
  assign w_new_flags = {i_alu_carry, (i_alu_result == '0), i_alu_result[DATA_W-1]};
  // Conditions 001..101 are the real branches; 000/110/111 never wait on flags.
  assign w_is_branch = (i_condition >= 3'd1) && (i_condition <= 3'd5);

  // Violations: done with nothing outstanding, or a second start while pending.
  assign w_perr_set  = ((r_state == IDLE) && i_alu_done) ||
                       ((r_state == PENDING) && i_alu_start && !i_alu_done);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: a start always leaves/keeps us pending; an accepted done
  // without a new start returns to idle. A start during pending is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_alu_start) w_state_nxt = PENDING;
      PENDING: if (i_alu_done && !i_alu_start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flag register, update counter and sticky protocol error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flags     <= 3'b000;
      r_upd_count <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_flags     <= w_new_flags;
        r_upd_count <= r_upd_count + 1'b1;
      end
      if (w_perr_set) r_proto_err <= 1'b1;
    end
  end

  // Output logic: flags, validity and branch stall.
  always_comb begin
    o_flags        = r_flags;
    o_flags_valid  = (r_state == IDLE);
    o_branch_stall = (r_state == PENDING) && w_is_branch;
`ifdef FLAG_FORWARD_EN
    // Fresh flags are known in the done cycle, so release the branch one cycle early.
    if (w_accept) begin
      o_flags        = w_new_flags;
      o_flags_valid  = 1'b1;
      o_branch_stall = 1'b0;
    end
`endif
  end

  assign o_proto_err = r_proto_err;
  assign o_upd_count = r_upd_count;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed-vector bench for flag_unit (default widths).
module tb_flag_unit;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_start, alu_done, alu_carry;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        condition;
  logic [2:0]        flags;
  logic              flags_valid, branch_stall, proto_err;
  logic [CNT_W-1:0]  upd_count;

  int n_vec = 0;
  int n_err = 0;

  // Done-cycle expectations differ when forwarding is compiled in.
`ifdef FLAG_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  flag_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_start(alu_start), .i_alu_done(alu_done),
    .i_alu_result(alu_result), .i_alu_carry(alu_carry),
    .i_condition(condition),
    .o_flags(flags), .o_flags_valid(flags_valid), .o_branch_stall(branch_stall),
    .o_proto_err(proto_err), .o_upd_count(upd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic s, input logic d, input logic [DATA_W-1:0] r,
                     input logic c, input logic [2:0] cond);
    alu_start = s; alu_done = d; alu_result = r; alu_carry = c; condition = cond;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, '0, 0, 3'b000);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    // Reset state after idling.
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_valid", 32'(flags_valid), 32'h1);
    chk("rst_stall", 32'(branch_stall), 32'h0);
    chk("rst_perr",  32'(proto_err), 32'h0);
    chk("rst_cnt",   32'(upd_count), 32'h0);

    // Single op: start, one wait cycle, done with result 0 / carry 1.
    drv(1, 0, '0, 0, 3'b000); tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("op1_valid_c2", 32'(flags_valid), 32'h0);
    tick();
    drv(0, 1, '0, 1, 3'b010); #1;
    chk("op1_valid_done", 32'(flags_valid), 32'(FWD));
    chk("op1_flags_done", 32'(flags), FWD ? 32'h6 : 32'h0);
    chk("op1_stall_done", 32'(branch_stall), FWD ? 32'h0 : 32'h1);
    tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("op1_flags", 32'(flags), 32'h6);
    chk("op1_valid", 32'(flags_valid), 32'h1);
    chk("op1_cnt",   32'(upd_count), 32'h1);

    // Branch stall with condition held; walk the condition codes while pending.
    drv(1, 0, '0, 0, 3'b010); #1;
    chk("stall_idle", 32'(branch_stall), 32'h0);
    tick();
    drv(0, 0, '0, 0, 3'b010); #1;
    chk("stall_bz", 32'(branch_stall), 32'h1);
    condition = 3'b110; #1; chk("stall_c110", 32'(branch_stall), 32'h0);
    condition = 3'b111; #1; chk("stall_c111", 32'(branch_stall), 32'h0);
    condition = 3'b000; #1; chk("stall_c000", 32'(branch_stall), 32'h0);
    condition = 3'b001; #1; chk("stall_c001", 32'(branch_stall), 32'h1);
    condition = 3'b101; #1; chk("stall_c101", 32'(branch_stall), 32'h1);
    condition = 3'b010;
    tick();
    drv(0, 1, 32'd7, 0, 3'b010); #1;
    chk("stall_done", 32'(branch_stall), FWD ? 32'h0 : 32'h1);
    tick();
    drv(0, 0, '0, 0, 3'b010);
    chk("stall_after", 32'(branch_stall), 32'h0);
    chk("op2_flags", 32'(flags), 32'h0);
    chk("op2_cnt", 32'(upd_count), 32'h2);
    condition = 3'b000;

    // Back-to-back ops.
    drv(1, 0, '0, 0, 3'b000); tick();
    drv(1, 1, 32'h8000_0000, 0, 3'b000); tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("b2b_flags1", 32'(flags), 32'h1);
    chk("b2b_pending", 32'(flags_valid), 32'h0);
    chk("b2b_cnt1", 32'(upd_count), 32'h3);
    drv(0, 1, 32'd5, 1, 3'b000); tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("b2b_flags2", 32'(flags), 32'h4);
    chk("b2b_valid", 32'(flags_valid), 32'h1);
    chk("b2b_cnt2", 32'(upd_count), 32'h4);
    chk("b2b_perr", 32'(proto_err), 32'h0);

    // Spurious done in IDLE: flags and count unchanged, sticky error.
    drv(0, 1, '0, 1, 3'b000); tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("spur_perr",  32'(proto_err), 32'h1);
    chk("spur_flags", 32'(flags), 32'h4);
    chk("spur_cnt",   32'(upd_count), 32'h4);
    chk("spur_valid", 32'(flags_valid), 32'h1);
    tick();
    chk("spur_sticky", 32'(proto_err), 32'h1);

    // Reset clears the error; then a second start while pending.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_perr", 32'(proto_err), 32'h0);
    chk("rst2_cnt",  32'(upd_count), 32'h0);
    chk("rst2_flags", 32'(flags), 32'h0);
    drv(1, 0, '0, 0, 3'b000); tick();
    chk("dbl_perr0", 32'(proto_err), 32'h0);
    tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("dbl_perr", 32'(proto_err), 32'h1);
    chk("dbl_pending", 32'(flags_valid), 32'h0);

    // Reset while pending, then a now-spurious done.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstp_valid", 32'(flags_valid), 32'h1);
    chk("rstp_perr0", 32'(proto_err), 32'h0);
    drv(0, 1, '0, 1, 3'b000); tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("rstp_perr", 32'(proto_err), 32'h1);
    chk("rstp_flags", 32'(flags), 32'h0);
    chk("rstp_cnt", 32'(upd_count), 32'h0);
    chk("rstp_valid2", 32'(flags_valid), 32'h1);

    // Counter wrap: 256 accepted updates bring it back to 0.
    drv(1, 0, '0, 0, 3'b000); tick();
    for (int i = 0; i < 255; i++) begin
      drv(1, 1, DATA_W'(i), 0, 3'b000); tick();
    end
    chk("wrap_cnt255", 32'(upd_count), 32'hFF);
    drv(0, 1, 32'd3, 0, 3'b000); tick();
    drv(0, 0, '0, 0, 3'b000);
    chk("wrap_cnt", 32'(upd_count), 32'h0);
    chk("wrap_valid", 32'(flags_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
